branch_unit: RTL

BRANCH_UNIT -- requirements
Module: branch_unit

---
 rtl/branch_unit.sv | 125 ++++++++++++
 1 files changed

// File: rtl/branch_unit.sv
// branch_unit: branch resolution with a 2-bit saturating-counter branch
// history table. It predicts the IF-stage PC, resolves the ID/EX branch and
// raises a one-cycle flush on a mispredict.
// Optional build macro BRANCH_STATS_EN adds saturating resolved-branch and
// mispredict counters. Without it, brCount and mispCount are tied to zero.
module branch_unit #(
  parameter int              PCW       = 8,
  parameter int              BHT_DEPTH = 16,
  parameter int              OPW       = 4,
  parameter logic [OPW-1:0]  BEQ_OP    = 4'b1101
) (
  input  logic            clk,
  input  logic            rest,
  input  logic [PCW-1:0]  ifPC,
  output logic            predTaken,
  input  logic [PCW-1:0]  IDEXPC,
  input  logic [OPW-1:0]  IDEXOp_Code,
  input  logic            Branch,
  input  logic            IDEXPredTaken,
  input  logic            CompareFlag,
  input  logic            SR_Flag,
  output logic            brTaken,
  output logic            flush,
  output logic [15:0]     brCount,
  output logic [15:0]     mispCount
);

  localparam int IDXW = $clog2(BHT_DEPTH);

  logic [1:0]      bht_q [BHT_DEPTH];
  logic [1:0]      bht_d [BHT_DEPTH];
  logic            br_taken_q, br_taken_d;
  logic            flush_q, flush_d;
  logic            cond;
  logic            valid;
  logic            mispredict;
  logic [IDXW-1:0] if_idx;
  logic [IDXW-1:0] ex_idx;
  logic            unused_pc_bits;

  assign if_idx         = ifPC[IDXW-1:0];
  assign ex_idx         = IDEXPC[IDXW-1:0];
  assign unused_pc_bits = ^{ifPC, IDEXPC};

  // Reading the registered table gives the pre-update value on an index collision.
  assign predTaken = bht_q[if_idx][1];

  // Resolve the ID/EX branch. The instruction behind a flush is wrong-path and ignored.
  always_comb begin
    cond       = (IDEXOp_Code == BEQ_OP) ? !CompareFlag : !SR_Flag;
    valid      = Branch && !flush_q;
    mispredict = valid && (cond != IDEXPredTaken);
    br_taken_d = valid && cond;
    flush_d    = mispredict;
  end

  // Step the resolved branch's saturating counter toward the actual outcome.
  always_comb begin
    bht_d = bht_q;
    if (valid) begin
      if (cond) begin
        if (bht_q[ex_idx] != 2'b11) begin
          bht_d[ex_idx] = bht_q[ex_idx] + 2'b01;
        end
      end else begin
        if (bht_q[ex_idx] != 2'b00) begin
          bht_d[ex_idx] = bht_q[ex_idx] - 2'b01;
        end
      end
    end
  end

  // Table and resolution registers. Reset sets every entry to weakly not-taken.
  always_ff @(posedge clk) begin
    if (!rest) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= 2'b01;
      end
      br_taken_q <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      bht_q      <= bht_d;
      br_taken_q <= br_taken_d;
      flush_q    <= flush_d;
    end
  end

  assign brTaken = br_taken_q;
  assign flush   = flush_q;

`ifdef BRANCH_STATS_EN
  logic [15:0] br_count_q, br_count_d;
  logic [15:0] misp_count_q, misp_count_d;

  // Count valid branches and mispredicts. Both counters hold at all-ones.
  always_comb begin
    br_count_d   = br_count_q;
    misp_count_d = misp_count_q;
    if (valid && (br_count_q != 16'hFFFF)) begin
      br_count_d = br_count_q + 16'd1;
    end
    if (mispredict && (misp_count_q != 16'hFFFF)) begin
      misp_count_d = misp_count_q + 16'd1;
    end
  end

  // Statistics registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rest) begin
      br_count_q   <= 16'd0;
      misp_count_q <= 16'd0;
    end else begin
      br_count_q   <= br_count_d;
      misp_count_q <= misp_count_d;
    end
  end

  assign brCount   = br_count_q;
  assign mispCount = misp_count_q;
`else
  assign brCount   = 16'd0;
  assign mispCount = 16'd0;
`endif

endmodule
